// File: rtl/memory_map_pkg.sv
// Shared address map, funct3 access codes and UART state encoding
// for the data-memory stage and its peripherals.
package memory_map_pkg;

    localparam logic [31:0] LEDS_ADDR        = 32'h1000_0000;
    localparam logic [31:0] CYCLES_ADDR      = 32'h1000_0004;
    localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_0008;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_000C;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// Transmit-only 8N1 UART; each bit is held BAUD_DIVISOR clocks.
// tx is decoded from state so an async reset idles the line at once.
module uart_transmitter
    import memory_map_pkg::*;
#(
    parameter int BAUD_DIVISOR = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIVISOR - 1);

    uart_state_t state;
    uart_state_t next_state;

    logic [CW-1:0] baud_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift_data;
    logic          bit_done;

    assign bit_done = (baud_count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= UART_IDLE;
            baud_count <= '0;
            bit_index  <= '0;
            shift_data <= '0;
        end else begin
            state <= next_state;
            if (state == UART_IDLE) begin
                baud_count <= '0;
                bit_index  <= '0;
                if (start) shift_data <= data;
            end else if (bit_done) begin
                baud_count <= '0;
                if (state == UART_DATA) bit_index <= bit_index + 3'd1;
            end else begin
                baud_count <= baud_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            UART_IDLE:  if (start) next_state = UART_START;
            UART_START: if (bit_done) next_state = UART_DATA;
            UART_DATA:  if (bit_done && bit_index == 3'd7) next_state = UART_STOP;
            UART_STOP:  if (bit_done) next_state = UART_IDLE;
            default:    next_state = UART_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != UART_IDLE);
        unique case (state)
            UART_START: tx = 1'b0;
            UART_DATA:  tx = shift_data[bit_index];
            default:    tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Data-memory stage: word RAM with byte/half lanes plus LEDS, CYCLES
// and UART registers. Loads are combinational; stores commit on the edge.
module data_memory
    import memory_map_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int BAUD_DIVISOR = 104
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [2:0]  access_size,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] word_index;
    logic [31:0]   cycles;
    logic          uart_busy;
    logic          uart_start;

    logic sel_ram;
    logic sel_leds;
    logic sel_cycles;
    logic sel_uart_data;
    logic sel_uart_status;
    logic is_word;
    logic store_ok;

    logic [3:0]  byte_en;
    logic [31:0] lane_data;
    logic [31:0] raw_word;
    logic [31:0] shifted;

    assign word_index      = address[AW+1:2];
    assign sel_ram         = ((address >> (AW + 2)) == 32'd0);
    assign sel_leds        = (address == LEDS_ADDR);
    assign sel_cycles      = (address == CYCLES_ADDR);
    assign sel_uart_data   = (address == UART_DATA_ADDR);
    assign sel_uart_status = (address == UART_STATUS_ADDR);
    assign is_word         = (access_size == F3_WORD);
    assign store_ok        = write_enable & ~misaligned;

    always_comb begin
        misaligned = 1'b1;
        case (access_size)
            F3_BYTE, F3_BYTE_U: misaligned = 1'b0;
            F3_HALF, F3_HALF_U: misaligned = address[0];
            F3_WORD:            misaligned = (address[1:0] != 2'b00);
            default:            misaligned = 1'b1;
        endcase
    end

    // Replicate store data across lanes so byte_en alone picks the target.
    always_comb begin
        byte_en   = 4'b0000;
        lane_data = write_data;
        case (access_size)
            F3_BYTE: begin
                byte_en   = 4'b0001 << address[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            F3_HALF: begin
                byte_en   = 4'b0011 << address[1:0];
                lane_data = {2{write_data[15:0]}};
            end
            F3_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (store_ok && sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[word_index][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds   <= '0;
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (store_ok && is_word && sel_leds) leds <= write_data[7:0];
        end
    end

    assign uart_start = store_ok & is_word & sel_uart_data & ~uart_busy;

    uart_transmitter #(
        .BAUD_DIVISOR(BAUD_DIVISOR)
    ) u_uart (
        .clock(clock),
        .reset(reset),
        .start(uart_start),
        .data (write_data[7:0]),
        .tx   (uart_tx),
        .busy (uart_busy)
    );

    always_comb begin
        raw_word = '0;
        unique case (1'b1)
            sel_ram:         raw_word = ram[word_index];
            sel_leds:        raw_word = {24'd0, leds};
            sel_cycles:      raw_word = cycles;
            sel_uart_status: raw_word = {31'd0, uart_busy};
            default:         raw_word = '0;
        endcase
    end

    assign shifted = raw_word >> {address[1:0], 3'b000};

    always_comb begin
        read_data = '0;
        if (!misaligned) begin
            case (access_size)
                F3_BYTE:   read_data = {{24{shifted[7]}}, shifted[7:0]};
                F3_HALF:   read_data = {{16{shifted[15]}}, shifted[15:0]};
                F3_WORD:   read_data = raw_word;
                F3_BYTE_U: read_data = {24'd0, shifted[7:0]};
                F3_HALF_U: read_data = {16'd0, shifted[15:0]};
                default:   read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory against a byte-array reference model,
// plus directed RAM, LED, CYCLES and UART frame scenarios.
module tb_data_memory;
    import memory_map_pkg::*;

    localparam int DEPTH     = 1024;
    localparam int BAUD      = 4;
    localparam int RAM_BYTES = DEPTH * 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [2:0]  access_size = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        misaligned;
    logic [7:0]  leds;
    logic        uart_tx;

    data_memory #(
        .DEPTH_WORDS (DEPTH),
        .BAUD_DIVISOR(BAUD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .write_enable(write_enable),
        .access_size (access_size),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .misaligned  (misaligned),
        .leds        (leds),
        .uart_tx     (uart_tx)
    );

    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0]  model_ram [RAM_BYTES];
    logic [7:0]  model_leds = 8'd0;
    logic [31:0] cyc_model;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc_model <= 32'd0;
        else       cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic model_misal(input logic [2:0] sz,
                                         input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return a[1:0] != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_raw(input logic [31:0] a, input int n);
        logic [31:0] v = 32'd0;
        if (a < RAM_BYTES) begin
            for (int i = 0; i < n; i++) v |= 32'(model_ram[int'(a) + i]) << (8 * i);
        end else if (a == LEDS_ADDR) v = {24'd0, model_leds};
        else if (a == CYCLES_ADDR) v = cyc_model;
        else v = 32'd0;
        if (n == 1) v &= 32'hFF;
        if (n == 2) v &= 32'hFFFF;
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] sz,
                                               input logic [31:0] a);
        logic [31:0] r;
        if (model_misal(sz, a)) return 32'd0;
        case (sz)
            3'd0: begin r = model_raw(a, 1); return {{24{r[7]}}, r[7:0]}; end
            3'd1: begin r = model_raw(a, 2); return {{16{r[15]}}, r[15:0]}; end
            3'd2: return model_raw(a, 4);
            3'd4: return model_raw(a, 1);
            3'd5: return model_raw(a, 2);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
        int n;
        if (model_misal(sz, a) || sz > 3'd2) return;
        n = 1 << sz;
        if (a < RAM_BYTES) begin
            for (int i = 0; i < n; i++) model_ram[int'(a) + i] = wd[8*i +: 8];
        end else if (a == LEDS_ADDR && n == 4) begin
            model_leds = wd[7:0];
        end
    endtask

    // Entered and left at a falling edge; checks land mid-low-phase.
    task automatic access(input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis);
        write_enable = we;
        access_size  = sz;
        address      = a;
        write_data   = wd;
        #1;
        rd  = read_data;
        mis = misaligned;
        check("read_data", read_data, model_read(sz, a));
        check("misaligned", {31'd0, misaligned}, {31'd0, model_misal(sz, a)});
        check("leds", {24'd0, leds}, {24'd0, model_leds});
        if (we) model_store(sz, a, wd);
        @(posedge clock);
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        mis;
    logic [31:0] a;
    logic        we;
    logic [9:0]  frame;

    initial begin
        access_size = F3_WORD;
        address     = UART_STATUS_ADDR;
        #1;
        check("reset_leds", {24'd0, leds}, 32'd0);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_busy", read_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        access(1'b0, F3_WORD, CYCLES_ADDR, 32'd0, rd, mis);
        check("cycles_10", rd, 32'd10);
        access(1'b1, F3_WORD, CYCLES_ADDR, 32'hFFFF_0000, rd, mis);
        check("cycles_11", rd, 32'd11);
        access(1'b0, F3_WORD, CYCLES_ADDR, 32'd0, rd, mis);
        check("cycles_wr_ignored", rd, 32'd12);

        for (int w = 0; w < DEPTH; w++)
            access(1'b1, F3_WORD, 32'(w * 4), $urandom, rd, mis);

        access(1'b1, F3_WORD, 32'h10, 32'hDEAD_BEEF, rd, mis);
        access(1'b0, F3_BYTE_U, 32'h11, 32'd0, rd, mis);
        check("lbu_11", rd, 32'h0000_00BE);
        access(1'b0, F3_BYTE, 32'h13, 32'd0, rd, mis);
        check("lb_13", rd, 32'hFFFF_FFDE);
        access(1'b0, F3_HALF_U, 32'h12, 32'd0, rd, mis);
        check("lhu_12", rd, 32'h0000_DEAD);
        access(1'b1, F3_BYTE, 32'h12, 32'h77, rd, mis);
        access(1'b0, F3_WORD, 32'h10, 32'd0, rd, mis);
        check("sb_merge", rd, 32'hDE77_BEEF);
        access(1'b0, F3_WORD, 32'h02, 32'd0, rd, mis);
        check("lw_mis_flag", {31'd0, mis}, 32'd1);
        check("lw_mis_data", rd, 32'd0);
        access(1'b1, F3_HALF, 32'h11, 32'hBBBB, rd, mis);
        check("sh_mis_flag", {31'd0, mis}, 32'd1);
        access(1'b0, F3_WORD, 32'h10, 32'd0, rd, mis);
        check("sh_mis_unchanged", rd, 32'hDE77_BEEF);

        access(1'b1, F3_WORD, LEDS_ADDR, 32'h1A5, rd, mis);
        check("leds_sw", {24'd0, leds}, 32'hA5);
        access(1'b0, F3_WORD, LEDS_ADDR, 32'd0, rd, mis);
        check("leds_lw", rd, 32'hA5);
        access(1'b1, F3_BYTE, LEDS_ADDR, 32'h3C, rd, mis);
        check("leds_sb_ignored", {24'd0, leds}, 32'hA5);

        access(1'b1, F3_WORD, 32'(RAM_BYTES), 32'h1234_5678, rd, mis);
        access(1'b0, F3_WORD, 32'(RAM_BYTES), 32'd0, rd, mis);
        check("beyond_ram", rd, 32'd0);
        access(1'b1, F3_WORD, 32'(RAM_BYTES - 4), 32'hCAFE_F00D, rd, mis);
        access(1'b0, F3_WORD, 32'(RAM_BYTES - 4), 32'd0, rd, mis);
        check("ram_top", rd, 32'hCAFE_F00D);

        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 63));
                5: a = 32'(RAM_BYTES - 8 + $urandom_range(0, 15));
                6: a = LEDS_ADDR + 32'($urandom_range(0, 3));
                7: a = CYCLES_ADDR + 32'($urandom_range(0, 11));
                8: a = $urandom;
                default: a = LEDS_ADDR;
            endcase
            we = 1'($urandom_range(0, 1));
            if (a == UART_DATA_ADDR) we = 1'b0;
            access(we, 3'($urandom_range(0, 7)), a, $urandom, rd, mis);
        end
        check("tx_idle", {31'd0, uart_tx}, 32'd1);

        frame = {1'b1, 8'h55, 1'b0};
        write_enable = 1'b1;
        access_size  = F3_WORD;
        address      = UART_DATA_ADDR;
        write_data   = 32'h55;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 10 * BAUD; k++) begin
            write_enable = (k == 10);
            address      = (k == 10) ? UART_DATA_ADDR : UART_STATUS_ADDR;
            write_data   = 32'hFF;
            #1;
            check($sformatf("tx_bit%0d", k / BAUD), {31'd0, uart_tx},
                  {31'd0, frame[k / BAUD]});
            if (k != 10) check("busy_frame", read_data, 32'd1);
            @(posedge clock);
            @(negedge clock);
        end
        write_enable = 1'b0;
        address      = UART_STATUS_ADDR;
        #1;
        check("busy_clear", read_data, 32'd0);
        check("tx_after", {31'd0, uart_tx}, 32'd1);

        @(negedge clock);
        write_enable = 1'b1;
        address      = UART_DATA_ADDR;
        write_data   = 32'hA3;
        @(posedge clock);
        @(negedge clock);
        write_enable = 1'b0;
        address      = UART_STATUS_ADDR;
        #1;
        check("busy_2nd", read_data, 32'd1);
        check("tx_start_2nd", {31'd0, uart_tx}, 32'd0);
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b1;
        model_leds = 8'd0;
        #1;
        check("abort_tx", {31'd0, uart_tx}, 32'd1);
        check("abort_busy", read_data, 32'd0);
        check("abort_leds", {24'd0, leds}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        access(1'b0, F3_WORD, CYCLES_ADDR, 32'd0, rd, mis);
        check("cycles_post_reset", rd, 32'd0);
        access(1'b0, F3_WORD, LEDS_ADDR, 32'd0, rd, mis);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Data-memory stage for the single-cycle RISC-V core. It sits directly downstream of the datapath: it consumes the datapath's ALU result as the address and its write data for stores, and returns load data to the datapath's read-data input within the same cycle. It combines a word-organised RAM, byte/halfword access handling, and a small memory-mapped peripheral block: LED register, free-running cycle counter and a transmit-only UART.

## Interface
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- BAUD_DIVISOR, 104, clock cycles per UART bit; must be 2 or more.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- write_enable  in  1  store strobe from the controller.
- access_size  in  3  instruction funct3 field.
- address  in  32  byte address, driven by the datapath's ALU_result.
- write_data  in  32  store data, driven by the datapath's write_data.
- read_data  out  32  load result, fed to the datapath's read_data.
- misaligned  out  1  current access is not naturally aligned.
- leds  out  8  LED register.
- uart_tx  out  1  serial output; idle high.

## Operation
- Address map:
  - RAM occupies 0x0000_0000 to DEPTH_WORDS*4-1. The word index is address[log2(DEPTH_WORDS)+1:2].
  - 0x1000_0000 LEDS: read/write; bits 7:0 are used and upper bits read as 0.
  - 0x1000_0004 CYCLES: read-only; writes are ignored.
  - 0x1000_0008 UART_DATA: write-only; reads return 0.
  - 0x1000_000C UART_STATUS: read-only; bit0 is busy.
  - All other addresses read 0 and ignore writes.
- Load access_size codes:
  - 000 lb and 001 lh: sign-extended.
  - 010 lw.
  - 100 lbu and 101 lhu: zero-extended.
  - Lanes are selected by address[1:0], little-endian.
- Store access_size codes:
  - 000 sb, 001 sh, 010 sw.
  - RAM byte enables are derived from address[1:0]; untouched bytes keep their value.
  - Peripheral registers accept sw only. Narrower stores to peripherals are ignored.
- misaligned is combinational and goes high for:
  - halfword access with address[0]=1;
  - word access with address[1:0]≠00;
  - access_size 011, 110 or 111.
- While misaligned is high, read_data=0 and the store is suppressed.
- CYCLES increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- UART transmitter:
  - A sw to UART_DATA while not busy latches write_data[7:0] and starts a frame.
  - A write while busy is dropped silently.
  - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held BAUD_DIVISOR cycles.
- UART FSM states:
  - IDLE: uart_tx=1. Goes to START on an accepted write.
  - START: goes to DATA after the bit time.
  - DATA: a 3-bit index counts 0 to 7; after bit 7 goes to STOP.
  - STOP: goes to IDLE after the bit time.
  - busy = (state≠IDLE).

## Timing
- Reads are combinational, with zero latency, so the single-cycle datapath completes a load within one cycle.
- Stores and register writes take effect at the rising edge with write_enable high.
- Read-during-write to the same address returns the old data in that cycle and the new data from the next cycle.
- CYCLES read returns the pre-increment value of that cycle.
- UART accepted write at edge N:
  - busy=1 and uart_tx=0 from cycle N+1.
  - Total frame is 10*BAUD_DIVISOR cycles.
  - busy=0 and a new write is accepted from cycle N+1+10*BAUD_DIVISOR.
- Reset values:
  - read_data follows the address (combinational).
  - leds=0, CYCLES=0, UART state=IDLE, uart_tx=1, busy=0.
  - RAM contents are not reset.
- Reset asserted mid-frame aborts the transmission immediately: uart_tx=1 and busy=0 asynchronously.

## Structure
- Shared package `memory_map_pkg` holds:
  - peripheral addresses;
  - funct3 access codes;
  - the UART state enum.
- Sub-module `uart_transmitter`:
  - inputs: clock, reset, start, data[7:0];
  - outputs: tx, busy;
  - parameter: BAUD_DIVISOR.
- RAM storage, lane steering, extension and address decode live in data_memory.

## Test plan
- sw 0xDEADBEEF @0x10; lbu @0x11 -> 0x000000BE; lb @0x13 -> 0xFFFFFFDE; lhu @0x12 -> 0x0000DEAD.
- sb 0x77 @0x12 over the word 0xDEADBEEF -> lw @0x10 = 0xDE77BEEF.
- lw @0x02 and sh @0x01 -> misaligned=1, read_data=0, RAM unchanged.
- sw 0x1A5 to 0x1000_0000 -> leds=0xA5; lw -> 0x000000A5. sb to the same address -> leds unchanged.
- Reset, then read CYCLES after 10 idle cycles -> 10. Write CYCLES -> value unaffected.
- With BAUD_DIVISOR=4, sw 0x55 to UART_DATA:
  - uart_tx pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles;
  - a second write mid-frame is dropped;
  - busy clears after 40 cycles;
  - reset mid-frame forces uart_tx=1.
